// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: hazard controller for a five-stage pipeline, covering EX operand forwarding, load-use stalls and branch flushes.
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   id_*                   decoded ID-stage instruction (valid, sources, dest, write/load flags)
//   ex_branch_taken        EX resolved a taken branch/jump this cycle
//   pc_write, ifid_write   PC and IF/ID enables (low while stalling)
//   ifid_flush             clear IF/ID to a NOP
//   idex_bubble            load a NOP into ID/EX
//   fwd_a, fwd_b           EX operand select: 00 regfile, 10 MEM ALU_out, 01 WB bus_w
//   stage_valid            {wb,mem,ex} scoreboard valid bits
module pipeline_hazard_unit #(
    parameter int REG_ADDR_W     = 5,
    parameter int LOAD_LATENCY   = 1,
    parameter int BRANCH_PENALTY = 1,
    parameter int ZERO_REG_FIXED = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [2:0]            stage_valid
);
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic                  reg_write;
        logic                  mem_read;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic                  uses_rs;
        logic                  uses_rt;
    } slot_t;

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] LSTALL  = 2'd1;
    localparam logic [1:0] FLUSH   = 2'd2;
    localparam logic [2:0] LL_INIT = 3'(LOAD_LATENCY - 1);
    localparam logic [2:0] BP_INIT = 3'(BRANCH_PENALTY - 1);

    slot_t      ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_slot;
    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       load_use, wb_unused;

    // A hard-wired r0 never carries a dependency
    function automatic logic live(input logic [REG_ADDR_W-1:0] r);
        return !(ZERO_REG_FIXED != 0 && r == '0);
    endfunction

    // Loads in MEM have no data yet, so only ALU results forward from MEM
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src, input logic uses,
                                           input slot_t m, input slot_t w);
        if (!uses || !live(src)) return 2'b00;
        if (m.valid && m.reg_write && !m.mem_read && m.dest == src) return 2'b10;
        if (w.valid && w.reg_write && w.dest == src) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        id_slot  = '{id_valid, id_dest, id_reg_write, id_mem_read, id_rs, id_rt, id_uses_rs, id_uses_rt};
        load_use = id_valid && ex_q.valid && ex_q.mem_read && ex_q.reg_write &&
                   ((id_uses_rs && live(id_rs) && ex_q.dest == id_rs) ||
                    (id_uses_rt && live(id_rt) && ex_q.dest == id_rt));
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            cnt_d       = BP_INIT;
            state_d     = (BP_INIT != 3'd0) ? FLUSH : RUN;
        end else if (state_q == RUN && load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            cnt_d       = LL_INIT;
            state_d     = (LL_INIT != 3'd0) ? LSTALL : RUN;
        end else if (state_q == LSTALL || state_q == FLUSH) begin
            pc_write    = state_q == FLUSH;
            ifid_write  = state_q == FLUSH;
            ifid_flush  = state_q == FLUSH;
            idex_bubble = 1'b1;
            cnt_d       = cnt_q - 3'd1;
            // The cycle that decrements to zero is the last one spent here
            state_d     = (cnt_q <= 3'd1) ? RUN : state_q;
        end
        if (reset) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            state_d     = RUN;
            cnt_d       = 3'd0;
        end
        ex_d        = idex_bubble ? '0 : id_slot;
        mem_d       = ex_q;
        wb_d        = mem_q;
        fwd_a       = reset ? 2'b00 : fwd_sel(ex_q.rs, ex_q.uses_rs, mem_q, wb_q);
        fwd_b       = reset ? 2'b00 : fwd_sel(ex_q.rt, ex_q.uses_rt, mem_q, wb_q);
        stage_valid = reset ? 3'b000 : {wb_q.valid, mem_q.valid, ex_q.valid};
        wb_unused   = ^{wb_q.mem_read, wb_q.rs, wb_q.rt, wb_q.uses_rs, wb_q.uses_rt};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit: directed checks of forwarding, stalls, flushes and reset on two parameterisations.
module tb_pipeline_hazard_unit;
    logic       clock = 1'b0, reset = 1'b1;
    logic       id_valid = 1'b0, id_uses_rs = 1'b0, id_uses_rt = 1'b0;
    logic       id_reg_write = 1'b0, id_mem_read = 1'b0, ex_branch_taken = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_dest = '0;
    logic       pw_a, iw_a, fl_a, bu_a, pw_b, iw_b, fl_b, bu_b;
    logic [1:0] fa_a, fb_a, fa_b, fb_b;
    logic [2:0] sv_a, sv_b;
    int         checks = 0, failures = 0;

    always #5 clock = ~clock;

    pipeline_hazard_unit #(.LOAD_LATENCY(1), .BRANCH_PENALTY(1)) u_a (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
        .pc_write(pw_a), .ifid_write(iw_a), .ifid_flush(fl_a), .idex_bubble(bu_a),
        .fwd_a(fa_a), .fwd_b(fb_a), .stage_valid(sv_a));

    pipeline_hazard_unit #(.LOAD_LATENCY(3), .BRANCH_PENALTY(2)) u_b (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
        .pc_write(pw_b), .ifid_write(iw_b), .ifid_flush(fl_b), .idex_bubble(bu_b),
        .fwd_a(fa_b), .fwd_b(fb_b), .stage_valid(sv_b));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic go(input logic v, input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                      input logic urt, input logic [4:0] d, input logic rw, input logic mr, input logic br);
        @(negedge clock);
        {id_valid, id_rs, id_uses_rs, id_rt, id_uses_rt} = {v, rs, urs, rt, urt};
        {id_dest, id_reg_write, id_mem_read, ex_branch_taken} = {d, rw, mr, br};
        #1;
    endtask

    task automatic nop(input logic br);
        go(0, 0, 0, 0, 0, 0, 0, 0, br);
    endtask

    initial begin
        nop(0);
        check("rst_pw_a", pw_a, 1);
        check("rst_iw_a", iw_a, 1);
        check("rst_fl_a", fl_a, 0);
        check("rst_bu_a", bu_a, 0);
        check("rst_fa_a", fa_a, 0);
        check("rst_sv_a", sv_a, 0);
        check("rst_pw_b", pw_b, 1);
        check("rst_sv_b", sv_b, 0);
        nop(0);
        reset = 1'b0;
        go(1, 1, 1, 2, 1, 3, 1, 0, 0);
        check("t1_idle_fa", fa_a, 0);
        check("t1_idle_pw", pw_a, 1);
        go(1, 3, 1, 1, 1, 4, 1, 0, 0);
        go(1, 0, 1, 3, 1, 7, 1, 0, 0);
        check("t1_mem_fa", fa_a, 2);
        check("t1_mem_fb", fb_a, 0);
        check("t1_sv", sv_a, 3);
        nop(0);
        check("t1_r0_fa", fa_a, 0);
        check("t1_wb_fb", fb_a, 1);
        check("t1_sv_full", sv_a, 7);
        go(1, 0, 0, 0, 0, 5, 1, 0, 0);
        go(1, 0, 0, 0, 0, 5, 1, 0, 0);
        go(1, 1, 1, 5, 1, 8, 1, 0, 0);
        nop(0);
        check("t2_dbl_fb", fb_a, 2);
        check("t2_dbl_fa", fa_a, 0);
        go(1, 1, 1, 0, 0, 2, 1, 1, 0);
        go(1, 2, 1, 3, 1, 6, 1, 0, 0);
        check("t3_pw_a", pw_a, 0);
        check("t3_iw_a", iw_a, 0);
        check("t3_bu_a", bu_a, 1);
        check("t3_fl_a", fl_a, 0);
        check("t3_pw_b1", pw_b, 0);
        go(1, 2, 1, 3, 1, 6, 1, 0, 0);
        check("t3_release_pw_a", pw_a, 1);
        check("t3_release_bu_a", bu_a, 0);
        check("t3_pw_b2", pw_b, 0);
        nop(0);
        check("t3_wb_fa", fa_a, 1);
        check("t3_pw_b3", pw_b, 0);
        check("t3_iw_b3", iw_b, 0);
        nop(0);
        check("t3_release_pw_b", pw_b, 1);
        check("t3_release_bu_b", bu_b, 0);
        go(1, 1, 1, 0, 0, 2, 1, 1, 0);
        go(1, 2, 1, 3, 1, 6, 1, 0, 0);
        check("t4_stall_pw_b", pw_b, 0);
        check("t4_stall_bu_b", bu_b, 1);
        go(1, 2, 1, 3, 1, 6, 1, 0, 1);
        check("t4_abort_fl_b", fl_b, 1);
        check("t4_abort_pw_b", pw_b, 1);
        check("t4_abort_bu_b", bu_b, 1);
        nop(0);
        check("t4_flush2_fl_b", fl_b, 1);
        check("t4_flush2_pw_b", pw_b, 1);
        nop(0);
        check("t4_run_fl_b", fl_b, 0);
        check("t4_run_bu_b", bu_b, 0);
        go(1, 1, 1, 2, 1, 9, 1, 0, 0);
        go(1, 1, 1, 2, 1, 10, 1, 0, 1);
        check("t5_fl_b1", fl_b, 1);
        check("t5_bu_b1", bu_b, 1);
        check("t5_fl_a1", fl_a, 1);
        go(1, 1, 1, 2, 1, 11, 1, 0, 0);
        check("t5_fl_b2", fl_b, 1);
        check("t5_bu_b2", bu_b, 1);
        check("t5_fl_a2", fl_a, 0);
        check("t5_sv_b2", sv_b, 2);
        nop(0);
        check("t5_fl_b3", fl_b, 0);
        check("t5_sv_b3", sv_b, 4);
        go(1, 1, 1, 2, 1, 0, 1, 0, 0);
        go(1, 0, 1, 0, 1, 5, 1, 0, 0);
        nop(0);
        check("t6_r0_fa", fa_a, 0);
        check("t6_r0_fb", fb_a, 0);
        go(1, 1, 1, 0, 0, 0, 1, 1, 0);
        go(1, 0, 1, 0, 1, 5, 1, 0, 0);
        check("t6_r0_load_pw_a", pw_a, 1);
        check("t6_r0_load_bu_a", bu_a, 0);
        check("t6_r0_load_pw_b", pw_b, 1);
        go(1, 1, 1, 0, 0, 4, 1, 1, 0);
        go(0, 4, 1, 4, 1, 5, 1, 0, 0);
        check("t6_novalid_pw_a", pw_a, 1);
        check("t6_novalid_bu_a", bu_a, 0);
        go(1, 1, 1, 0, 0, 2, 1, 1, 0);
        go(1, 2, 1, 3, 1, 6, 1, 0, 0);
        check("t6_stall_pw_b", pw_b, 0);
        go(1, 2, 1, 3, 1, 6, 1, 0, 0);
        check("t6_lstall_pw_b", pw_b, 0);
        reset = 1'b1;
        #1;
        check("t6_in_rst_pw_b", pw_b, 1);
        @(posedge clock);
        #1 reset = 1'b0;
        go(1, 2, 1, 3, 1, 6, 1, 0, 0);
        check("t6_after_rst_pw_b", pw_b, 1);
        check("t6_after_rst_bu_b", bu_b, 0);
        check("t6_after_rst_sv_b", sv_b, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
